// File: rtl/wb_drac_bridge_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// wb_drac_bridge_pkg : widths, FSM states and mask helper     (rev 1.0)
// ------------------------------------------------------------------------
package wb_drac_bridge_pkg;

  localparam int LINE_BYTES = 32;
  localparam int LANE_BITS  = 3;
  localparam int WB_DW      = 32;
  localparam int DDR_DW     = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_REQ = 2'd1,
    ST_WR_REQ = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // DDR mask polarity is inverted: a set bit keeps the byte untouched.
  function automatic logic [LINE_BYTES-1:0] lane_mask(input logic [LANE_BITS-1:0] lane,
                                                      input logic [3:0]           sel);
    logic [LINE_BYTES-1:0] m;
    m = '1;
    m[{lane, 2'b00} +: 4] = ~sel;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_drac_linebuf.sv
`default_nettype none
// ------------------------------------------------------------------------
// wb_drac_linebuf : one 256-bit line with tag/valid, lane mux and merge  (rev 1.0)
// ------------------------------------------------------------------------
module wb_drac_linebuf
  import wb_drac_bridge_pkg::*;
#(
  parameter int TAG_W = 29
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DDR_DW-1:0]    load_dat_i,
  input  logic [TAG_W-1:0]     load_tag_i,
  input  logic                 inval_i,
  input  logic                 wr_i,
  input  logic [LANE_BITS-1:0] wr_lane_i,
  input  logic [3:0]           wr_sel_i,
  input  logic [WB_DW-1:0]     wr_dat_i,
  input  logic [LANE_BITS-1:0] rd_lane_i,
  output logic [WB_DW-1:0]     rd_dat_o,
  input  logic [TAG_W-1:0]     cmp_tag_i,
  output logic                 hit_o
);

  logic [DDR_DW-1:0] line_q;
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      line_q  <= load_dat_i;
      tag_q   <= load_tag_i;
      valid_q <= 1'b1;
    end else if (wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel_i[b]) line_q[{wr_lane_i, 5'b00000} + b*8 +: 8] <= wr_dat_i[b*8 +: 8];
      end
    end
  end

  assign rd_dat_o = line_q[{rd_lane_i, 5'b00000} +: WB_DW];
  assign hit_o    = valid_q && (tag_q == cmp_tag_i);

endmodule
`default_nettype wire

// File: rtl/wb_drac_bridge.sv
`default_nettype none
// ------------------------------------------------------------------------
// wb_drac_bridge : Wishbone classic 32-bit slave to drac 256-bit line port  (rev 1.0)
// ------------------------------------------------------------------------
module wb_drac_bridge
  import wb_drac_bridge_pkg::*;
#(
  parameter int ADR_WIDTH = 34,
  parameter int TIMEOUT   = 1023,
  parameter int READ_BUF  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADR_WIDTH-1:0]  adr_i,
  input  logic [WB_DW-1:0]      dat_i,
  output logic [WB_DW-1:0]      dat_o,
  input  logic [3:0]            sel_i,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  srd,
  output logic                  swr,
  output logic [ADR_WIDTH-6:0]  sa,
  output logic [DDR_DW-1:0]     swdat,
  output logic [LINE_BYTES-1:0] smsk,
  input  logic [DDR_DW-1:0]     srdat,
  input  logic                  srdy
);

  localparam int TAG_W = ADR_WIDTH - 5;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [LANE_BITS-1:0] lane_q;
  logic [3:0]           sel_q;
  logic                 abort_q;

  logic [TAG_W-1:0]     line_adr;
  logic [LANE_BITS-1:0] lane_adr;
  logic [1:0]           unused_adr;
  logic                 req_take, in_req, live, tmo, rd_hit;
  logic                 buf_hit, buf_load, buf_wr, buf_inval;
  logic [TAG_W-1:0]     cmp_tag;
  logic [WB_DW-1:0]     buf_rdat;

  assign line_adr   = adr_i[ADR_WIDTH-1:5];
  assign lane_adr   = adr_i[4:2];
  assign unused_adr = adr_i[1:0];
  assign req_take   = cyc_i & stb_i & ~ack_o & ~err_o;
  assign in_req     = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign live       = cyc_i & ~abort_q;
  assign tmo        = (TIMEOUT != 0) && (32'(cnt_q) + 32'd1 == 32'(TIMEOUT));
  assign rd_hit     = (READ_BUF != 0) && buf_hit;

  // In IDLE the tag compare serves the incoming read; afterwards it serves write coherence.
  assign cmp_tag   = (state_q == ST_IDLE) ? line_adr : sa;
  assign buf_load  = (state_q == ST_RD_REQ) && srdy;
  assign buf_wr    = (state_q == ST_WR_REQ) && srdy && buf_hit;
  assign buf_inval = in_req && !srdy && tmo;

  wb_drac_linebuf #(.TAG_W(TAG_W)) u_linebuf (
    .clk        (clk),
    .reset      (reset),
    .load_i     (buf_load),
    .load_dat_i (srdat),
    .load_tag_i (sa),
    .inval_i    (buf_inval),
    .wr_i       (buf_wr),
    .wr_lane_i  (lane_q),
    .wr_sel_i   (sel_q),
    .wr_dat_i   (swdat[WB_DW-1:0]),
    .rd_lane_i  (lane_adr),
    .rd_dat_o   (buf_rdat),
    .cmp_tag_i  (cmp_tag),
    .hit_o      (buf_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      sel_q   <= '0;
      abort_q <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
      srd     <= 1'b0;
      swr     <= 1'b0;
      sa      <= '0;
      swdat   <= '0;
      smsk    <= '1;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_take) begin
            lane_q  <= lane_adr;
            abort_q <= 1'b0;
            cnt_q   <= '0;
            if (we_i) begin
              swr     <= 1'b1;
              sa      <= line_adr;
              swdat   <= {8{dat_i}};
              smsk    <= lane_mask(lane_adr, sel_i);
              sel_q   <= sel_i;
              state_q <= ST_WR_REQ;
            end else if (rd_hit) begin
              dat_o   <= buf_rdat;
              ack_o   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              srd     <= 1'b1;
              sa      <= line_adr;
              state_q <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ, ST_WR_REQ: begin
          // The DDR side cannot be cancelled, so an abandoned cycle only suppresses the response.
          if (!cyc_i) abort_q <= 1'b1;
          if (srdy) begin
            srd <= 1'b0;
            swr <= 1'b0;
            if (live) begin
              ack_o   <= 1'b1;
              state_q <= ST_RESP;
              if (state_q == ST_RD_REQ) dat_o <= srdat[{lane_q, 5'b00000} +: WB_DW];
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (tmo) begin
            srd <= 1'b0;
            swr <= 1'b0;
            if (live) begin
              err_o   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_drac_bridge.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_wb_drac_bridge : randomized scoreboard bench with a word-level memory model  (rev 1.0)
// ------------------------------------------------------------------------
module tb_wb_drac_bridge;

  localparam int TMO = 16;

  logic          clk, reset;
  logic [33:0]   adr_i;
  logic [31:0]   dat_i, dat_o;
  logic [3:0]    sel_i;
  logic          we_i, stb_i, cyc_i, ack_o, err_o;
  logic          srd, swr, srdy;
  logic [28:0]   sa;
  logic [255:0]  swdat, srdat;
  logic [31:0]   smsk;

  wb_drac_bridge #(.ADR_WIDTH(34), .TIMEOUT(TMO), .READ_BUF(1)) dut (
    .clk(clk), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .sel_i(sel_i), .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .err_o(err_o), .srd(srd), .swr(swr), .sa(sa), .swdat(swdat), .smsk(smsk),
    .srdat(srdat), .srdy(srdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [28:0] lines [4];
  logic [31:0] refmem [4][8];
  logic [31:0] ddrmem [4][8];
  bit          mvalid = 0;
  int          mtag = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every ack/err must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (srd && swr) chk("srd_swr_exclusive", 256'(1'b1), 256'(1'b0));
      if (ack_o || err_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 256'({ack_o, err_o}), 256'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_kind", 256'({ack_o, err_o}), e.err ? 256'(2'b01) : 256'(2'b10));
          if (e.chk && !e.err) chk("rd_data", 256'(dat_o), 256'(e.dat));
        end
      end
    end
  end

  // mode: 0 normal, 1 DDR never answers, 2 master drops cyc, 3 reset mid-request
  task automatic do_txn(input bit we, input int k, input int lane, input logic [31:0] d,
                        input logic [3:0] s, input int mode_in, input int delay_in);
    exp_t          e;
    bit            hit, done, got;
    int            rc, mode, delay;
    logic [31:0]   mexp;
    logic [255:0]  line;
    logic [2:0]    lane3;
    mode  = mode_in;
    delay = delay_in;
    lane3 = 3'(lane);
    hit   = !we && mvalid && (mtag == k);
    if (hit) mode = 0;
    if (mode == 2 && delay < 3) delay = 3;
    for (int i = 0; i < 32; i++) mexp[i] = !(((i / 4) == lane) && s[i % 4]);
    if (mode == 0) begin
      e.err = 0; e.chk = !we; e.dat = refmem[k][lane];
      sbq.push_back(e);
    end else if (mode == 1) begin
      e.err = 1; e.chk = 0; e.dat = '0;
      sbq.push_back(e);
    end
    @(negedge clk);
    adr_i = {lines[k], lane3, 2'($urandom)};
    dat_i = d; sel_i = s; we_i = we; cyc_i = 1'b1; stb_i = 1'b1;
    rc = 0; done = 0; got = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      srdy = 1'b0;
      if (ack_o || err_o) begin
        got = 1; done = 1;
      end else if (srd || swr) begin
        rc++;
        if (rc == 1) begin
          chk("req_kind", 256'({srd, swr}), we ? 256'(2'b01) : 256'(2'b10));
          chk("sa", 256'(sa), 256'(lines[k]));
          if (we) begin
            chk("swdat", swdat, {8{d}});
            chk("smsk", 256'(smsk), 256'(mexp));
          end
        end
        if (mode == 3) begin
          reset = 1'b1; done = 1;
        end else begin
          if (mode == 2 && rc == 2) begin cyc_i = 1'b0; stb_i = 1'b0; end
          if ((mode == 0 || mode == 2) && rc == delay) begin
            for (int w = 0; w < 8; w++) line[w*32 +: 32] = ddrmem[k][w];
            if (swr)
              for (int b = 0; b < 32; b++)
                if (!smsk[b]) ddrmem[k][b/4][(b%4)*8 +: 8] = swdat[b*8 +: 8];
            srdat = line; srdy = 1'b1;
          end
        end
      end else if (mode == 2 && rc > 0) begin
        done = 1;
      end
    end
    if (mode == 3) begin
      @(posedge clk); #1;
      chk("rst_srd_swr", 256'({srd, swr}), 256'(0));
      chk("rst_smsk", 256'(smsk), 256'(32'hFFFF_FFFF));
      chk("rst_sa", 256'(sa), 256'(0));
      reset = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
      mvalid = 0;
      return;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    if (mode != 2) chk("resp_seen", 256'(got), 256'(1));
    case (mode)
      0: begin
        chk("ddr_used", 256'(rc > 0), 256'(!hit));
        if (!hit) chk("req_hold", 256'(rc), 256'(delay));
      end
      1: chk("tmo_cycles", 256'(rc), 256'(TMO));
      2: begin
        chk("abort_hold", 256'(rc), 256'(delay));
        chk("abort_noack", 256'(got), 256'(0));
      end
      default: ;
    endcase
    if (mode == 0 || mode == 2) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (s[b]) refmem[k][lane][b*8 +: 8] = d[b*8 +: 8];
      end else if (!hit) begin
        mvalid = 1; mtag = k;
      end
    end else begin
      mvalid = 0;
    end
  endtask

  task automatic late_srdy();
    @(negedge clk);
    for (int w = 0; w < 8; w++) srdat[w*32 +: 32] = $urandom;
    srdy = 1'b1;
    @(negedge clk);
    srdy = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, mode;
    reset = 1'b1; adr_i = '0; dat_i = '0; sel_i = '0; we_i = 0; stb_i = 0; cyc_i = 0;
    srdy = 0; srdat = '0;
    lines[0] = 29'h1; lines[1] = 29'h2;
    lines[2] = 29'(($urandom << 2) | 32'h3); lines[3] = 29'(($urandom << 2) | 32'h10);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) begin
        refmem[i][j] = $urandom;
        ddrmem[i][j] = refmem[i][j];
      end
    refmem[0][1] = 32'hCAFEBABE; ddrmem[0][1] = 32'hCAFEBABE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c % 5 == 2) begin srdy = 1'b1; srdat = {8{32'hDEADBEEF}}; end
      @(negedge clk);
      srdy = 1'b0;
    end
    chk("rst_ack", 256'(ack_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    chk("rst_dat_o", 256'(dat_o), 256'(0));
    chk("rst_srd", 256'(srd), 256'(0));
    chk("rst_swr", 256'(swr), 256'(0));
    chk("rst_sa_idle", 256'(sa), 256'(0));
    chk("rst_swdat", swdat, 256'(0));
    chk("rst_smsk_idle", 256'(smsk), 256'(32'hFFFF_FFFF));

    do_txn(0, 0, 1, 32'h0, 4'h0, 0, 5);              // 0x24 miss
    do_txn(0, 0, 2, 32'h0, 4'h0, 0, 1);              // 0x28 hit
    do_txn(1, 1, 2, 32'h11223344, 4'b0101, 0, 3);    // 0x48 write
    do_txn(1, 0, 1, 32'hA5B6C7D8, 4'b1000, 0, 2);    // write hit on buffered line
    do_txn(0, 0, 1, 32'h0, 4'h0, 0, 1);              // merged word from buffer
    do_txn(0, 1, 3, 32'h0, 4'h0, 1, 1);              // timeout
    late_srdy();
    do_txn(0, 0, 1, 32'h0, 4'h0, 0, 2);              // buffer was invalidated
    do_txn(0, 2, 4, 32'h0, 4'h0, 2, 5);              // cyc dropped mid-read
    do_txn(0, 2, 6, 32'h0, 4'h0, 0, 1);              // aborted read still filled buffer
    do_txn(1, 3, 0, 32'h55667788, 4'hF, 3, 1);       // reset mid-write

    for (int t = 0; t < 200; t++) begin
      k    = $urandom_range(0, 3);
      mode = $urandom_range(0, 19);
      mode = (mode < 3) ? mode + 1 : 0;
      do_txn(1'($urandom), k, $urandom_range(0, 7), $urandom, 4'($urandom), mode,
             $urandom_range(1, 8));
      if (mode == 1) late_srdy();
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", 256'(sbq.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
